// File: rtl/frame_checker.sv
// frame_checker: validates 16-bit AXI-Stream Ethernet-style frames, captures header fields and payload byte sum, counts good/bad frames; results on an 8-bit Avalon-MM slave.
// Latency: a frame's result (visible regs, counters, status) is readable from the cycle after its tlast beat; readdata is valid one cycle after chipselect&&read.
// Backpressure: never stalls the stream; tready is held high on every cycle after reset. Optional feature macro: FRAME_CHECKER_MAC_FILTER_EN (dst MAC filter, regs 23-29).
module frame_checker #(
  parameter int MAX_LEN = 1500,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  writedata,
  input  logic        write,
  input  logic        chipselect,
  input  logic [7:0]  address,
  input  logic        read,
  output logic [7:0]  readdata,
  input  logic [15:0] ingress_port_tdata,
  input  logic        ingress_port_tlast,
  input  logic        ingress_port_tvalid,
  output logic        ingress_port_tready
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  typedef enum logic [1:0] {
    S_PRE  = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] widx_q, widx_d;

  // Shadow copies filled while the frame streams in; MAC byte 0 sits in bits [47:40].
  logic [47:0] dst_sh_q, dst_sh_d;
  logic [47:0] src_sh_q, src_sh_d;
  logic [15:0] len_sh_q, len_sh_d;
  logic [15:0] type_sh_q, type_sh_d;
  logic [31:0] csum_sh_q, csum_sh_d;

  // Software-visible copies, only updated by an accepted good frame.
  logic [47:0] dst_q, src_q;
  logic [15:0] len_q, type_q;
  logic [31:0] csum_q;

  logic [CNT_W-1:0] good_cnt_q, err_cnt_q;
  logic [2:0]       status_q;
  logic             tready_q;
  logic [7:0]       readdata_q;
  logic [7:0]       rd_mux;

  logic        beat;
  logic        pre_ok;
  logic [15:0] len_w;
  logic [15:0] exp_last;
  logic        frame_good, err_pre, err_len, frame_err;
  logic        filt_hit, good_take;
  logic        stat_clr;

  assign beat      = ingress_port_tvalid && tready_q;
  assign len_w     = {ingress_port_tdata[7:0], ingress_port_tdata[15:8]};
  assign exp_last  = 16'd11 + {1'b0, len_sh_q[15:1]};
  assign pre_ok    = (widx_q == 16'd3) ? (ingress_port_tdata == 16'hAAAB)
                                       : (ingress_port_tdata == 16'hAAAA);
  assign frame_err = err_pre | err_len;
  assign stat_clr  = chipselect && write && (address == 8'd22);

  // Frame state and shadow registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_PRE;
      widx_q    <= '0;
      dst_sh_q  <= '0;
      src_sh_q  <= '0;
      len_sh_q  <= '0;
      type_sh_q <= '0;
      csum_sh_q <= '0;
    end else begin
      state_q   <= state_d;
      widx_q    <= widx_d;
      dst_sh_q  <= dst_sh_d;
      src_sh_q  <= src_sh_d;
      len_sh_q  <= len_sh_d;
      type_sh_q <= type_sh_d;
      csum_sh_q <= csum_sh_d;
    end
  end

  // Framing checks: next state, shadow loads and per-frame verdict pulses
  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    dst_sh_d   = dst_sh_q;
    src_sh_d   = src_sh_q;
    len_sh_d   = len_sh_q;
    type_sh_d  = type_sh_q;
    csum_sh_d  = csum_sh_q;
    frame_good = 1'b0;
    err_pre    = 1'b0;
    err_len    = 1'b0;
    if (beat) begin
      widx_d = widx_q + 16'd1;
      case (state_q)
        S_PRE: begin
          if (!pre_ok) begin
            err_pre = 1'b1;
            state_d = S_DROP;
          end else if (ingress_port_tlast) begin
            err_len = 1'b1;
          end else if (widx_q == 16'd3) begin
            state_d   = S_HDR;
            csum_sh_d = '0;
          end
        end
        S_HDR: begin
          case (widx_q)
            16'd4:   dst_sh_d[47:32] = ingress_port_tdata;
            16'd5:   dst_sh_d[31:16] = ingress_port_tdata;
            16'd6:   dst_sh_d[15:0]  = ingress_port_tdata;
            16'd7:   src_sh_d[47:32] = ingress_port_tdata;
            16'd8:   src_sh_d[31:16] = ingress_port_tdata;
            16'd9:   src_sh_d[15:0]  = ingress_port_tdata;
            16'd10:  len_sh_d        = len_w;
            16'd11:  type_sh_d       = ingress_port_tdata;
            default: ;
          endcase
          if ((widx_q == 16'd10) && (len_w[0] || (len_w > MAX_LEN_W))) begin
            err_len = 1'b1;
            state_d = S_DROP;
          end else if (widx_q == 16'd11) begin
            // Zero-length frames end on the type word.
            if (len_sh_q == 16'd0) begin
              if (ingress_port_tlast) begin
                frame_good = 1'b1;
              end else begin
                err_len = 1'b1;
                state_d = S_DROP;
              end
            end else if (ingress_port_tlast) begin
              err_len = 1'b1;
            end else begin
              state_d = S_PAY;
            end
          end else if (ingress_port_tlast) begin
            err_len = 1'b1;
          end
        end
        S_PAY: begin
          csum_sh_d = csum_sh_q + {24'd0, ingress_port_tdata[15:8]}
                                + {24'd0, ingress_port_tdata[7:0]};
          if (widx_q == exp_last) begin
            if (ingress_port_tlast) begin
              frame_good = 1'b1;
            end else begin
              err_len = 1'b1;
              state_d = S_DROP;
            end
          end else if (ingress_port_tlast) begin
            err_len = 1'b1;
          end
        end
        default: ;
      endcase
      // Every tlast closes the frame, whatever its verdict.
      if (ingress_port_tlast) begin
        state_d = S_PRE;
        widx_d  = '0;
      end
    end
  end

`ifdef FRAME_CHECKER_MAC_FILTER_EN
  logic [47:0]      filt_mac_q;
  logic [CNT_W-1:0] filt_cnt_q;

  assign filt_hit = frame_good && (filt_mac_q != 48'd0) && (dst_sh_d != filt_mac_q);

  // Filter MAC register writes (byte 0 at address 23)
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_mac_q <= '0;
    end else if (chipselect && write) begin
      case (address)
        8'd23:   filt_mac_q[47:40] <= writedata;
        8'd24:   filt_mac_q[39:32] <= writedata;
        8'd25:   filt_mac_q[31:24] <= writedata;
        8'd26:   filt_mac_q[23:16] <= writedata;
        8'd27:   filt_mac_q[15:8]  <= writedata;
        8'd28:   filt_mac_q[7:0]   <= writedata;
        default: ;
      endcase
    end
  end

  // Filtered-frame counter; shares the clear-then-increment rule with the other counters
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= (stat_clr ? '0 : filt_cnt_q) + {{(CNT_W-1){1'b0}}, filt_hit};
    end
  end
`else
  logic unused_wdata;
  assign unused_wdata = ^writedata;
  assign filt_hit     = 1'b0;
`endif

  assign good_take = frame_good && !filt_hit;

  // Publish the shadow copies when a good frame is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      dst_q  <= '0;
      src_q  <= '0;
      len_q  <= '0;
      type_q <= '0;
      csum_q <= '0;
    end else if (good_take) begin
      dst_q  <= dst_sh_d;
      src_q  <= src_sh_d;
      len_q  <= len_sh_d;
      type_q <= type_sh_d;
      csum_q <= csum_sh_d;
    end
  end

  // Counters and sticky status: a same-cycle clear applies first, then this cycle's event
  always_ff @(posedge clk) begin
    if (reset) begin
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
      status_q   <= '0;
    end else begin
      good_cnt_q <= (stat_clr ? '0 : good_cnt_q) + {{(CNT_W-1){1'b0}}, good_take};
      err_cnt_q  <= (stat_clr ? '0 : err_cnt_q) + {{(CNT_W-1){1'b0}}, frame_err};
      status_q   <= (stat_clr ? 3'b000 : status_q) | {err_len, err_pre, good_take};
    end
  end

  // Stream ready comes up the first cycle after reset and stays up
  always_ff @(posedge clk) begin
    if (reset) begin
      tready_q <= 1'b0;
    end else begin
      tready_q <= 1'b1;
    end
  end

  // Register map read mux
  always_comb begin
    rd_mux = 8'h00;
    case (address)
      8'd0:    rd_mux = dst_q[47:40];
      8'd1:    rd_mux = dst_q[39:32];
      8'd2:    rd_mux = dst_q[31:24];
      8'd3:    rd_mux = dst_q[23:16];
      8'd4:    rd_mux = dst_q[15:8];
      8'd5:    rd_mux = dst_q[7:0];
      8'd6:    rd_mux = src_q[47:40];
      8'd7:    rd_mux = src_q[39:32];
      8'd8:    rd_mux = src_q[31:24];
      8'd9:    rd_mux = src_q[23:16];
      8'd10:   rd_mux = src_q[15:8];
      8'd11:   rd_mux = src_q[7:0];
      8'd12:   rd_mux = len_q[7:0];
      8'd13:   rd_mux = len_q[15:8];
      8'd14:   rd_mux = type_q[15:8];
      8'd15:   rd_mux = type_q[7:0];
      8'd16:   rd_mux = csum_q[7:0];
      8'd17:   rd_mux = csum_q[15:8];
      8'd18:   rd_mux = csum_q[23:16];
      8'd19:   rd_mux = csum_q[31:24];
      8'd20:   rd_mux = 8'(good_cnt_q);
      8'd21:   rd_mux = 8'(err_cnt_q);
      8'd22:   rd_mux = {5'd0, status_q};
`ifdef FRAME_CHECKER_MAC_FILTER_EN
      8'd23:   rd_mux = filt_mac_q[47:40];
      8'd24:   rd_mux = filt_mac_q[39:32];
      8'd25:   rd_mux = filt_mac_q[31:24];
      8'd26:   rd_mux = filt_mac_q[23:16];
      8'd27:   rd_mux = filt_mac_q[15:8];
      8'd28:   rd_mux = filt_mac_q[7:0];
      8'd29:   rd_mux = 8'(filt_cnt_q);
`endif
      default: rd_mux = 8'h00;
    endcase
  end

  // Registered read data; zero whenever no read is in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= 8'h00;
    end else if (chipselect && read) begin
      readdata_q <= rd_mux;
    end else begin
      readdata_q <= 8'h00;
    end
  end

  assign readdata            = readdata_q;
  assign ingress_port_tready = tready_q;

endmodule
